cpu_step_ctrl: RTL and testbench

//  Board-input side of the CPU debug harness; display output is handled by the seven-segment path.

---
 rtl/cpu_step_ctrl_if.sv | 22 ++
 rtl/cpu_step_ctrl.sv | 128 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_ctrl_if.sv
// Board-side bundle for the CPU step controller: raw buttons in, CPU strobe and status out.
interface cpu_step_ctrl_if;
    logic        btn_step;
    logic        btn_run;
    logic        btn_sel;
    logic        cpu_en;
    logic        run_mode;
    logic [4:0]  reg_sel;
    logic [31:0] step_count;

    // Board / harness side: drives the buttons, observes the controller.
    modport master (
        output btn_step, btn_run, btn_sel,
        input  cpu_en, run_mode, reg_sel, step_count
    );

    // Controller side.
    modport slave (
        input  btn_step, btn_run, btn_sel,
        output cpu_en, run_mode, reg_sel, step_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU debug harness input stage: debounces step/run/select buttons and produces a
// one-cycle CPU clock-enable, either per step press or from a free-running divider,
// plus the register-select index for the display path.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 50000000,
    parameter int NUM_REGS        = 26
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_step_ctrl_if.slave bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = $clog2(RUN_DIV);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [4:0]       SEL_LAST = 5'(NUM_REGS - 1);

    // Channel indices into the per-button vectors.
    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_SEL  = 2;

    typedef enum logic {ST_STEP, ST_RUN} state_t;

    logic [2:0]            raw;
    logic [2:0]            sync_p0;
    logic [2:0]            sync_p1;
    logic [2:0]            stable;
    logic [2:0]            press;
    logic [2:0][DB_W-1:0]  db_cnt;

    state_t                state;
    logic [DIV_W-1:0]      div_cnt;
    logic                  cpu_en_q;
    logic                  run_mode_q;
    logic [31:0]           step_count_q;
    logic [4:0]            reg_sel_q;

    assign raw = {bus.btn_sel, bus.btn_run, bus.btn_step};

    assign bus.cpu_en     = cpu_en_q;
    assign bus.run_mode   = run_mode_q;
    assign bus.step_count = step_count_q;
    assign bus.reg_sel    = reg_sel_q;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: accept a new level after it persists, and flag the 0->1 acceptance as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            stable <= '0;
            press  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync_p1[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    stable[i] <= sync_p1[i];
                    // Press coincides with the rising edge of the stable level; releases give 0.
                    press[i]  <= sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Mode FSM and cpu_en generation; a mode toggle always wins over step or divider pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_STEP;
            div_cnt      <= '0;
            cpu_en_q     <= 1'b0;
            run_mode_q   <= 1'b0;
            step_count_q <= '0;
        end else begin
            cpu_en_q <= 1'b0;
            if (press[BTN_RUN]) begin
                div_cnt <= '0;
                if (state == ST_STEP) begin
                    state      <= ST_RUN;
                    run_mode_q <= 1'b1;
                end else begin
                    state      <= ST_STEP;
                    run_mode_q <= 1'b0;
                end
            end else if (state == ST_RUN) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt      <= '0;
                    cpu_en_q     <= 1'b1;
                    step_count_q <= step_count_q + 32'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else if (press[BTN_STEP]) begin
                cpu_en_q     <= 1'b1;
                step_count_q <= step_count_q + 32'd1;
            end
        end
    end

    // Register-select index advances per select press and wraps at the last register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_sel_q <= '0;
        end else if (press[BTN_SEL]) begin
            if (reg_sel_q == SEL_LAST) begin
                reg_sel_q <= '0;
            end else begin
                reg_sel_q <= reg_sel_q + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: vector table, hand sequences and randomized buttons
// against a history-based reference model.
module tb_cpu_step_ctrl;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int RUN_DIV         = 8;
    localparam int NUM_REGS        = 26;
    localparam int HIST            = 32;

    logic clk;
    logic rst_n;

    cpu_step_ctrl_if bus ();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RUN_DIV        (RUN_DIV),
        .NUM_REGS       (NUM_REGS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw sample history per button (index 0 newest).
    bit          m_hist   [3][HIST];
    bit          m_stable [3];
    bit          m_press  [3];
    bit          m_run;
    bit          m_cpu_en;
    int          m_enter;
    int          m_edge;
    int          m_sel;
    logic [31:0] m_cnt;

    typedef struct {
        bit step;
        bit run;
        bit sel;
        int hold;
        int idle;
        int exp_en;
        int exp_first;
        bit exp_mode;
        int exp_sel;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < HIST; k++) m_hist[b][k] = 1'b0;
            m_stable[b] = 1'b0;
            m_press[b]  = 1'b0;
        end
        m_run    = 1'b0;
        m_cpu_en = 1'b0;
        m_enter  = 0;
        m_edge   = 0;
        m_sel    = 0;
        m_cnt    = '0;
    endfunction

    // One clock edge of the behavioural model; raw is what the DUT samples at this edge.
    function automatic void model_edge(input bit [2:0] raw);
        bit en;
        bit v;
        int len;
        m_edge++;
        en = 1'b0;
        if (m_press[1]) begin
            m_run   = !m_run;
            m_enter = m_edge;
        end else if (m_run) begin
            en = ((m_edge - m_enter) % RUN_DIV) == 0;
        end else begin
            en = m_press[0];
        end
        if (m_press[2]) m_sel = (m_sel + 1) % NUM_REGS;
        m_cpu_en = en;
        if (en) m_cnt = m_cnt + 32'd1;
        for (int b = 0; b < 3; b++) begin
            for (int k = HIST - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = raw[b];
            // The debouncer sees the sample from two edges ago; a level is accepted once
            // it has been seen for DEBOUNCE_CYCLES consecutive edges.
            v   = m_hist[b][2];
            len = 0;
            for (int k = 2; k < HIST; k++) begin
                if (m_hist[b][k] != v) break;
                len++;
            end
            m_press[b] = 1'b0;
            if (v != m_stable[b] && len >= DEBOUNCE_CYCLES) begin
                m_stable[b] = v;
                m_press[b]  = v;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge({bus.btn_sel, bus.btn_run, bus.btn_step});
        #1;
        check("cycle {en,mode,sel,count}",
              {bus.cpu_en, bus.run_mode, bus.reg_sel, bus.step_count},
              {m_cpu_en, m_run, m_sel[4:0], m_cnt});
    endtask

    task automatic set_btns(input bit s, input bit r, input bit l);
        bus.btn_step = s;
        bus.btn_run  = r;
        bus.btn_sel  = l;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " cpu_en"},     bus.cpu_en,     0);
        check({tag, " run_mode"},   bus.run_mode,   0);
        check({tag, " reg_sel"},    bus.reg_sel,    0);
        check({tag, " step_count"}, bus.step_count, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    // Press one button pattern for hold cycles, release for idle cycles.
    task automatic press_btns(input bit s, input bit r, input bit l, input int hold, input int idle);
        set_btns(s, r, l);
        repeat (hold) tick();
        set_btns(0, 0, 0);
        repeat (idle) tick();
    endtask

    int cnt_en;
    int first_t;
    int rem [3];
    bit lvl [3];

    initial begin
        //                step run sel hold idle en first mode sel
        vec[0] = '{1'b1, 1'b0, 1'b0, 20, 10, 1,  7, 1'b0, 0};
        vec[1] = '{1'b1, 1'b0, 1'b0,  3, 10, 0, -1, 1'b0, 0};
        vec[2] = '{1'b1, 1'b0, 1'b0,  4, 10, 1,  7, 1'b0, 0};
        vec[3] = '{1'b0, 1'b0, 1'b1,  6, 10, 0, -1, 1'b0, 1};
        vec[4] = '{1'b1, 1'b0, 1'b1,  6, 10, 1,  7, 1'b0, 2};
        vec[5] = '{1'b0, 1'b1, 1'b0,  6, 11, 1, 15, 1'b1, 2};
        vec[6] = '{1'b1, 1'b0, 1'b0,  6, 17, 3,  6, 1'b1, 2};
        vec[7] = '{1'b0, 1'b1, 1'b0,  6, 10, 0, -1, 1'b0, 2};
        vec[8] = '{1'b1, 1'b0, 1'b0,  6, 10, 1,  7, 1'b0, 2};

        rst_n = 1'b1;
        set_btns(0, 0, 0);
        model_reset();
        #2;
        apply_reset();

        // Vector table: each record starts from idle buttons.
        for (int i = 0; i < 9; i++) begin
            cnt_en  = 0;
            first_t = -1;
            set_btns(vec[i].step, vec[i].run, vec[i].sel);
            for (int t = 1; t <= vec[i].hold + vec[i].idle; t++) begin
                if (t == vec[i].hold + 1) set_btns(0, 0, 0);
                tick();
                if (bus.cpu_en === 1'b1) begin
                    cnt_en++;
                    if (first_t < 0) first_t = t;
                end
            end
            check($sformatf("vec%0d en_count", i), cnt_en, vec[i].exp_en);
            check($sformatf("vec%0d first_en", i), first_t, vec[i].exp_first);
            check($sformatf("vec%0d run_mode", i), bus.run_mode, vec[i].exp_mode);
            check($sformatf("vec%0d reg_sel", i), bus.reg_sel, vec[i].exp_sel);
        end

        // Bounce and short glitches on step: nothing gets through.
        cnt_en = 0;
        for (int k = 0; k < 10; k++) begin
            bus.btn_step = ~bus.btn_step;
            tick();
            if (bus.cpu_en === 1'b1) cnt_en++;
        end
        for (int p = 0; p < 3; p++) begin
            bus.btn_step = 1'b1;
            repeat (3) begin tick(); if (bus.cpu_en === 1'b1) cnt_en++; end
            bus.btn_step = 1'b0;
            repeat (3) begin tick(); if (bus.cpu_en === 1'b1) cnt_en++; end
        end
        repeat (8) begin tick(); if (bus.cpu_en === 1'b1) cnt_en++; end
        check("bounce en_count", cnt_en, 0);
        check("bounce step_count", bus.step_count, 8);

        // Enter RUN, then run and step edges land in the same cycle: toggle wins.
        press_btns(0, 1, 0, 6, 10);
        check("run entered", bus.run_mode, 1);
        set_btns(1, 1, 0);
        for (int t = 1; t <= 16; t++) begin
            if (t == 7) set_btns(0, 0, 0);
            tick();
            if (t == 7) begin
                check("simul run_mode", bus.run_mode, 0);
                check("simul cpu_en t7", bus.cpu_en, 0);
            end
            if (t == 8) check("simul cpu_en t8", bus.cpu_en, 0);
        end

        // 27 select presses from reset: 1..25, 0, 1.
        apply_reset();
        for (int k = 1; k <= 27; k++) begin
            press_btns(0, 0, 1, 5, 7);
            check($sformatf("sel press %0d", k), bus.reg_sel, k % NUM_REGS);
        end

        // Reset mid-RUN with reg_sel=5 and step held through the release.
        repeat (4) press_btns(0, 0, 1, 5, 7);
        press_btns(0, 1, 0, 6, 10);
        repeat (5) tick();
        bus.btn_step = 1'b1;
        repeat (2) tick();
        check("pre-reset reg_sel", bus.reg_sel, 5);
        check("pre-reset run_mode", bus.run_mode, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async reset");
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        cnt_en  = 0;
        first_t = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.cpu_en === 1'b1) begin
                cnt_en++;
                if (first_t < 0) first_t = t;
            end
        end
        check("held-through-reset en_count", cnt_en, 1);
        check("held-through-reset first_en", first_t, 7);
        check("held-through-reset step_count", bus.step_count, 1);
        check("held-through-reset run_mode", bus.run_mode, 0);
        set_btns(0, 0, 0);
        repeat (10) tick();

        // Randomized button activity against the model.
        for (int b = 0; b < 3; b++) begin
            rem[b] = 0;
            lvl[b] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    rem[b] = int'($urandom_range(1, 12));
                end
                rem[b]--;
            end
            set_btns(lvl[0], lvl[1], lvl[2]);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
